mem_multi_beat_seq: RTL and testbench
=====================================

Name: mem_multi_beat_seq

Overview:
- Parametrised successor to the two-beat store splitter in the memory stage.
- Breaks one wide or multi-word load/store request into 1..MAX_BEATS sequential memory beats. Beat k goes to base_addr + k*BEAT_STRIDE.
- Holds the pipeline with a stall until the final beat is accepted. Adds a memory ready handshake, a flush, and illegal-length detection.
- Sits between the EX/MEM register and the data-memory port.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (64), address/data width.
- MAX_BEATS, 4, maximum beats per request (>=2).
- BEAT_STRIDE, 8, byte offset between consecutive beats.
- CNT_W, $clog2(MAX_BEATS+1), width of beat counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present; pipeline holds all req_* stable while stall=1.
- req_is_store  in  1  1=store, 0=load; passed through.
- base_addr  in  DATA_WIDTH  address of beat 0.
- num_beats  in  CNT_W  requested beat count; legal range 1..MAX_BEATS.
- flush  in  1  synchronous abort of the current sequence.
- mem_ready  in  1  memory accepts the presented beat this cycle.
- beat_valid  out  1  beat presented to memory.
- beat_addr  out  DATA_WIDTH  base_addr + beat_idx*BEAT_STRIDE, mod 2^DATA_WIDTH.
- beat_is_store  out  1  copy of req_is_store.
- beat_idx  out  CNT_W  index of the presented beat.
- beat_last  out  1  beat_idx == num_beats-1.
- stall  out  1  hold upstream pipeline.
- done  out  1  one-cycle pulse, registered, after the last beat is accepted.
- err_len  out  1  one-cycle pulse, registered, on an illegal num_beats.

Behaviour:
- State: a beat_idx register (CNT_W bits), a busy flag, and registered done/err_len.
- FSM has two states:
  - IDLE: beat_idx=0, busy=0.
  - RUN: busy=1.
- legal = (num_beats != 0) && (num_beats <= MAX_BEATS).
- Combinational outputs:
  - beat_valid = rst_n && req_valid && legal && !flush.
  - accept = beat_valid && mem_ready.
  - stall = beat_valid && !(accept && beat_last).
- Beat 0 is presented in the same cycle req_valid rises (zero latency, as the existing splitter does).
- Counter rules:
  - Accept of a non-last beat: beat_idx+1, busy=1.
  - Accept of the last beat: beat_idx=0, busy=0, done=1 next cycle.
  - No accept (mem_ready=0): beat_idx held, stall=1, beat_addr stable.
- num_beats=1: single beat; stall = !mem_ready; no RUN state entered.
- Illegal length while IDLE:
  - beat_valid=0, stall=0, so the request drops through without memory access.
  - err_len=1 next cycle.
- flush:
  - Forces beat_valid=0 and stall=0 in the same cycle.
  - Next edge: beat_idx=0, busy=0; no done pulse.
  - flush wins over a simultaneous accept.
- req_valid low while busy is a protocol violation. Treat it as an abort (same as flush) and flag it with a simulation-only assertion.
- Address arithmetic is unsigned and wraps at 2^DATA_WIDTH. No alignment checks.
- Reset values (async assert, sync deassert assumed upstream): beat_idx=0, busy=0, done=0, err_len=0. Combinational outputs are all 0 while rst_n=0.
- Reset mid-sequence discards remaining beats. The next request restarts at beat 0.
- Back-to-back requests: after the last accept, a new request may present beat 0 on the very next cycle. The done pulse of the old request overlaps beat 0 of the new one.

Decomposition:
- Package mem_seq_pkg holds:
  - typedef seq_state_e {IDLE, RUN};
  - localparam DEFAULT_BEAT_STRIDE = 8;
  - function beat_offset(idx) returning idx*BEAT_STRIDE.
- One natural sub-module: beat_counter (modulo counter with clear, enable and a terminal-count compare). It is reusable for a future load-gather unit.
- The existing mux2 is used for stall/valid gating.

Test Plan:
- Store, num_beats=2, base=0x1000, mem_ready=1 always:
  - Cycle 0: beat_addr=0x1000, stall=1.
  - Cycle 1: beat_addr=0x1008, stall=0, beat_last=1.
  - Cycle 2: done=1.
- Load, num_beats=4, base=0x2000, mem_ready low on cycles 1-2:
  - Addresses 0x2000, 0x2008 (held 3 cycles), 0x2010, 0x2018.
  - stall=1 for 5 cycles; done once.
- num_beats=0, then num_beats=5 (MAX_BEATS=4): beat_valid=0, stall=0, err_len pulses 1 cycle each.
- num_beats=4, flush asserted on beat 2: beat_valid=0 and stall=0 that cycle; no done. Next request at 0x3000 starts at beat_idx=0.
- base=0xFFFF_FFFF_FFFF_FFF8, num_beats=2 → second beat_addr=0x0 (wrap).
- rst_n low during beat 1 of a 3-beat request: all outputs 0 immediately. After release, the same request restarts at beat 0.

Source files
------------

// File: rtl/mem_multi_beat_seq_pkg.sv
// Shared types, defaults and helpers for the multi-beat memory sequencer.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

package mem_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

  localparam int DEFAULT_DATA_WIDTH  = `DATA_WIDTH;
  localparam int DEFAULT_MAX_BEATS   = 4;
  localparam int DEFAULT_BEAT_STRIDE = 8;

  // Byte offset of beat idx from the request base; wraps at the address width.
  function automatic logic [DEFAULT_DATA_WIDTH-1:0] beat_offset(input int unsigned idx,
                                                                input int unsigned stride);
    logic [DEFAULT_DATA_WIDTH-1:0] off;
    off = DEFAULT_DATA_WIDTH'(idx) * DEFAULT_DATA_WIDTH'(stride);
    return off;
  endfunction

endpackage

// File: rtl/mem_multi_beat_seq_if.sv
// Request / memory-beat bus of the multi-beat sequencer.
// Handshake: a beat transfers on a rising clk edge where beat_valid && mem_ready;
// beat_valid, beat_addr and beat_idx stay stable until that transfer, and the
// requester holds every req_* signal stable while stall is high.
interface mem_multi_beat_seq_if
  import mem_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_W      = $clog2(DEFAULT_MAX_BEATS + 1)
);
  logic                  req_valid;
  logic                  req_is_store;
  logic [DATA_WIDTH-1:0] base_addr;
  logic [CNT_W-1:0]      num_beats;
  logic                  flush;
  logic                  mem_ready;
  logic                  beat_valid;
  logic [DATA_WIDTH-1:0] beat_addr;
  logic                  beat_is_store;
  logic [CNT_W-1:0]      beat_idx;
  logic                  beat_last;
  logic                  stall;
  logic                  done;
  logic                  err_len;
  seq_state_e            state;

  modport master (
    output req_valid, req_is_store, base_addr, num_beats, flush, mem_ready,
    input  beat_valid, beat_addr, beat_is_store, beat_idx, beat_last, stall,
           done, err_len, state
  );

  modport slave (
    input  req_valid, req_is_store, base_addr, num_beats, flush, mem_ready,
    output beat_valid, beat_addr, beat_is_store, beat_idx, beat_last, stall,
           done, err_len, state
  );
endinterface

// File: rtl/mem_multi_beat_seq_beat_counter.sv
// Modulo counter with synchronous clear, enable and a terminal-count compare.
// On an enabled step at the terminal value it wraps back to zero.
module beat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         at_term
);
  logic [W-1:0] cnt_q;

  assign count   = cnt_q;
  assign at_term = (cnt_q == term);

  // Clear has priority over counting so an abort always returns to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= at_term ? '0 : cnt_q + W'(1);
    end
  end
endmodule

// File: rtl/mux2.sv
// Generic two-input multiplexer used for gating control signals.
module mux2 #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] y
);
  // sel=0 passes a, sel=1 passes b.
  always_comb y = sel ? b : a;
endmodule

// File: rtl/mem_multi_beat_seq.sv
// Splits one load/store request into 1..MAX_BEATS sequential memory beats at
// base_addr + k*BEAT_STRIDE, stalling the pipeline until the last beat is taken.
module mem_multi_beat_seq
  import mem_seq_pkg::*;
#(
  parameter int          DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int          MAX_BEATS   = DEFAULT_MAX_BEATS,
  parameter int unsigned BEAT_STRIDE = DEFAULT_BEAT_STRIDE,
  parameter int          CNT_W       = $clog2(MAX_BEATS + 1)
) (
  input logic                clk,
  input logic                rst_n,
  mem_multi_beat_seq_if.slave bus
);
  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] last_idx;
  logic             at_last;
  logic             busy;
  logic             legal;
  logic             req_ok;
  logic             beat_valid;
  logic             accept;
  logic             beat_last;
  logic             stall_raw;
  logic             stall;
  logic             abort;
  logic             done_q;
  logic             err_len_q;

  assign busy     = (state_q == RUN);
  assign legal    = (bus.num_beats != '0) && (bus.num_beats <= CNT_W'(MAX_BEATS));
  assign last_idx = bus.num_beats - CNT_W'(1);
  assign req_ok   = rst_n && bus.req_valid && legal;
  // Dropping req_valid mid-sequence is handled exactly like a flush.
  assign abort    = bus.flush || (busy && !bus.req_valid);

  // Flush suppresses the beat in the same cycle it is raised.
  mux2 #(.W(1)) u_valid_mux (
    .a   (req_ok),
    .b   (1'b0),
    .sel (bus.flush),
    .y   (beat_valid)
  );

  assign accept    = beat_valid && bus.mem_ready;
  assign beat_last = beat_valid && at_last;
  assign stall_raw = !(accept && beat_last);

  // Stall only while a beat is actually being presented.
  mux2 #(.W(1)) u_stall_mux (
    .a   (1'b0),
    .b   (stall_raw),
    .sel (beat_valid),
    .y   (stall)
  );

  beat_counter #(.W(CNT_W)) u_beat_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (abort),
    .en      (accept),
    .term    (last_idx),
    .count   (idx_q),
    .at_term (at_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: RUN after a non-final accept, back to IDLE on the final accept or an abort.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && !beat_last) state_d = RUN;
      RUN:  if (abort || (accept && beat_last)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered one-cycle status pulses: completion and illegal length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q    <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      done_q    <= accept && beat_last;
      err_len_q <= bus.req_valid && !legal && !busy;
    end
  end

  assign bus.beat_valid    = beat_valid;
  assign bus.beat_addr     = rst_n ? bus.base_addr + beat_offset(32'(idx_q), BEAT_STRIDE) : '0;
  assign bus.beat_is_store = rst_n && bus.req_is_store;
  assign bus.beat_idx      = idx_q;
  assign bus.beat_last     = beat_last;
  assign bus.stall         = stall;
  assign bus.done          = done_q;
  assign bus.err_len       = err_len_q;
  assign bus.state         = state_q;

  // The requester must keep req_valid high for the whole sequence.
  req_held_while_busy: assert property (
    @(posedge clk) disable iff (!rst_n) (busy && !bus.flush) |-> bus.req_valid
  );
endmodule

// File: tb/tb_mem_multi_beat_seq.sv
// Self-checking bench for mem_multi_beat_seq: directed scenarios plus random
// requests compared against a beat-count reference model.
module tb_mem_multi_beat_seq;
  import mem_seq_pkg::*;

  localparam int DW        = 64;
  localparam int MAXB      = 4;
  localparam int STRIDE    = 8;
  localparam int CW        = $clog2(MAXB + 1);

  logic clk;
  logic rst_n;

  mem_multi_beat_seq_if #(.DATA_WIDTH(DW), .CNT_W(CW)) bus ();

  mem_multi_beat_seq #(
    .DATA_WIDTH  (DW),
    .MAX_BEATS   (MAXB),
    .BEAT_STRIDE (STRIDE),
    .CNT_W       (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: beats already accepted in the current request.
  int m_sent  = 0;
  bit m_done  = 0;
  bit m_err   = 0;
  bit m_ended = 0;
  bit p_valid, p_last, p_legal;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Compare every output against the model on the falling edge.
  task automatic sample();
    logic [63:0] e_addr;
    logic        e_stall;
    @(negedge clk);
    p_legal = (int'(bus.num_beats) >= 1) && (int'(bus.num_beats) <= MAXB);
    p_valid = rst_n && bus.req_valid && p_legal && !bus.flush;
    p_last  = p_valid && (m_sent == int'(bus.num_beats) - 1);
    e_stall = p_valid && !(bus.mem_ready && p_last);
    e_addr  = rst_n ? bus.base_addr + 64'(m_sent) * 64'(STRIDE) : 64'h0;
    chk("beat_valid", 64'(bus.beat_valid), 64'(p_valid));
    chk("beat_addr", bus.beat_addr, e_addr);
    chk("beat_is_store", 64'(bus.beat_is_store), 64'(rst_n && bus.req_is_store));
    chk("beat_idx", 64'(bus.beat_idx), rst_n ? 64'(m_sent) : 64'h0);
    chk("beat_last", 64'(bus.beat_last), 64'(p_last));
    chk("stall", 64'(bus.stall), 64'(e_stall));
    chk("done", 64'(bus.done), 64'(rst_n && m_done));
    chk("err_len", 64'(bus.err_len), 64'(rst_n && m_err));
  endtask

  // Advance the model across the rising edge, then leave a settle gap for driving.
  task automatic advance();
    bit acc;
    @(posedge clk);
    if (!rst_n) begin
      m_sent = 0; m_done = 0; m_err = 0; m_ended = 1;
    end else begin
      acc    = p_valid && bus.mem_ready;
      m_done = acc && p_last;
      m_err  = bus.req_valid && !p_legal && (m_sent == 0);
      if (bus.flush || (m_sent > 0 && !bus.req_valid)) begin
        m_sent = 0; m_ended = 1;
      end else if (acc) begin
        if (p_last) begin m_sent = 0; m_ended = 1; end
        else m_sent++;
      end else if (m_err) begin
        m_ended = 1;
      end
    end
    #1;
  endtask

  task automatic set_req(input bit st, input logic [63:0] base, input int nb);
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.base_addr    = base;
    bus.num_beats    = CW'(nb);
    bus.flush        = 1'b0;
  endtask

  task automatic idle_cycle();
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.mem_ready = 1'b0;
    sample();
    advance();
  endtask

  // Drive one request to completion with random ready and optional random flush.
  task automatic run_req(input bit st, input logic [63:0] base, input int nb,
                         input int pct, input bit fl_en);
    set_req(st, base, nb);
    m_ended = 0;
    for (int c = 0; c < 64; c++) begin
      bus.mem_ready = ($urandom_range(0, 99) < pct);
      bus.flush     = fl_en && ($urandom_range(0, 19) == 0);
      sample();
      advance();
      bus.flush = 1'b0;
      if (m_ended) break;
    end
    if (!m_ended) chk("req_timeout", 64'h0, 64'h1);
  endtask

  initial begin
    logic [63:0] exp_addr[$];
    logic [5:0]  rdy;
    int          stall_cnt, done_cnt;
    logic [63:0] b;

    // Reset.
    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_is_store = 1'b0;
    bus.base_addr    = '0;
    bus.num_beats    = '0;
    bus.flush        = 1'b0;
    bus.mem_ready    = 1'b0;
    sample();
    chk("reset_state", 64'(bus.state), 64'(IDLE));
    advance();
    advance();
    rst_n = 1'b1;
    idle_cycle();

    // Store, two beats, memory always ready.
    set_req(1'b1, 64'h1000, 2);
    bus.mem_ready = 1'b1;
    sample();
    chk("s2_addr0", bus.beat_addr, 64'h1000);
    chk("s2_stall0", 64'(bus.stall), 64'h1);
    advance();
    sample();
    chk("s2_addr1", bus.beat_addr, 64'h1008);
    chk("s2_stall1", 64'(bus.stall), 64'h0);
    chk("s2_last1", 64'(bus.beat_last), 64'h1);
    advance();
    bus.req_valid = 1'b0;
    sample();
    chk("s2_done", 64'(bus.done), 64'h1);
    advance();

    // Load, four beats, memory not ready on cycles 1 and 2.
    set_req(1'b0, 64'h2000, 4);
    exp_addr = '{64'h2000, 64'h2008, 64'h2008, 64'h2008, 64'h2010, 64'h2018};
    rdy       = 6'b111001;
    stall_cnt = 0;
    done_cnt  = 0;
    for (int i = 0; i < 6; i++) begin
      bus.mem_ready = rdy[i];
      sample();
      chk("l4_addr", bus.beat_addr, exp_addr[i]);
      stall_cnt += int'(bus.stall);
      done_cnt  += int'(bus.done);
      advance();
    end
    bus.req_valid = 1'b0;
    sample();
    done_cnt += int'(bus.done);
    advance();
    chk("l4_stall_cycles", 64'(stall_cnt), 64'd5);
    chk("l4_done_count", 64'(done_cnt), 64'd1);

    // Illegal lengths: zero, then above the maximum.
    set_req(1'b0, 64'h4000, 0);
    bus.mem_ready = 1'b1;
    sample();
    chk("len0_valid", 64'(bus.beat_valid), 64'h0);
    chk("len0_stall", 64'(bus.stall), 64'h0);
    advance();
    set_req(1'b0, 64'h4000, 5);
    sample();
    chk("len0_err", 64'(bus.err_len), 64'h1);
    chk("len5_valid", 64'(bus.beat_valid), 64'h0);
    advance();
    bus.req_valid = 1'b0;
    sample();
    chk("len5_err", 64'(bus.err_len), 64'h1);
    advance();
    sample();
    chk("err_one_cycle", 64'(bus.err_len), 64'h0);
    advance();

    // Flush on beat 2 of four, then a fresh request.
    set_req(1'b1, 64'h5000, 4);
    bus.mem_ready = 1'b1;
    sample(); advance();
    sample(); advance();
    bus.flush = 1'b1;
    sample();
    chk("flush_valid", 64'(bus.beat_valid), 64'h0);
    chk("flush_stall", 64'(bus.stall), 64'h0);
    advance();
    set_req(1'b0, 64'h3000, 2);
    sample();
    chk("flush_no_done", 64'(bus.done), 64'h0);
    chk("flush_restart_idx", 64'(bus.beat_idx), 64'h0);
    chk("flush_restart_addr", bus.beat_addr, 64'h3000);
    advance();
    sample(); advance();
    idle_cycle();

    // Address wrap.
    set_req(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 2);
    bus.mem_ready = 1'b1;
    sample(); advance();
    sample();
    chk("wrap_addr", bus.beat_addr, 64'h0);
    advance();
    idle_cycle();

    // Reset during beat 1 of a three-beat request.
    b = 64'h0000_0000_0000_7000;
    set_req(1'b1, b, 3);
    bus.mem_ready = 1'b1;
    sample(); advance();
    rst_n = 1'b0;
    sample();
    chk("rst_valid", 64'(bus.beat_valid), 64'h0);
    chk("rst_addr", bus.beat_addr, 64'h0);
    chk("rst_stall", 64'(bus.stall), 64'h0);
    advance();
    rst_n = 1'b1;
    sample();
    chk("rst_restart_idx", 64'(bus.beat_idx), 64'h0);
    chk("rst_restart_addr", bus.beat_addr, b);
    advance();
    run_req(1'b1, b, 3, 100, 1'b0);
    idle_cycle();

    // Randomized requests, some back to back.
    for (int r = 0; r < 40; r++) begin
      int nb;
      nb = ($urandom_range(0, 3) != 0) ? $urandom_range(1, MAXB) : $urandom_range(0, 7);
      b  = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) b[63:8] = '1;
      run_req(1'($urandom_range(0, 1)), b, nb, $urandom_range(30, 100), 1'b1);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
